// File: rtl/sdram_port_model_if.sv
// Client command bus between an SDRAM client (master) and the memory-side
// responder (slave): command/address/data, read/write strobes, refresh handshake.
interface sdram_port_model_if;
  logic [1:0]  i_Command;
  logic [21:0] i_Data_Address;
  logic [31:0] i_Data_Write;
  logic [31:0] o_Data_Read;
  logic        o_Data_Read_Valid;
  logic        o_Data_Write_Done;
  logic        o_SDRAM_Requested;
  logic        i_SDRAM_Yield;

  modport master (
    output i_Command, i_Data_Address, i_Data_Write, i_SDRAM_Yield,
    input  o_Data_Read, o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested
  );

  modport slave (
    input  i_Command, i_Data_Address, i_Data_Write, i_SDRAM_Yield,
    output o_Data_Read, o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested
  );
endinterface

// File: rtl/sdram_port_model.sv
// On-chip RAM standing in for the SDRAM controller: burst sequencing with
// activation/read latency and a periodic refresh request/yield handshake.
module sdram_port_model #(
  parameter int BURST_LEN        = 8,
  parameter int ACT_CYCLES       = 2,
  parameter int READ_LATENCY     = 2,
  parameter int MEM_ADDR_W       = 12,
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_CYCLES   = 8
) (
  input logic                i_Clk,
  input logic                i_Rst_n,
  sdram_port_model_if.slave  bus
);

  localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;
  localparam int WAIT_MAX_A = (ACT_CYCLES > READ_LATENCY) ? ACT_CYCLES : READ_LATENCY;
  localparam int WAIT_MAX   = (WAIT_MAX_A > REFRESH_CYCLES) ? WAIT_MAX_A : REFRESH_CYCLES;
  localparam int WAIT_W     = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam int BEAT_W     = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN);
  localparam int REF_W      = (REFRESH_INTERVAL < 2) ? 1 : $clog2(REFRESH_INTERVAL);

  localparam logic [WAIT_W-1:0] ACT_LOAD  = WAIT_W'(ACT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] RL_LOAD   = WAIT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [WAIT_W-1:0] REF_LOAD  = WAIT_W'(REFRESH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_INTERVAL - 1);
  localparam logic [1:0]        CMD_READ  = 2'd1;
  localparam logic [1:0]        CMD_WRITE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ACTIVATE    = 3'd1,
    ST_READ_WAIT   = 3'd2,
    ST_READ_BURST  = 3'd3,
    ST_WRITE_BURST = 3'd4,
    ST_GAP         = 3'd5,
    ST_REFRESH     = 3'd6
  } state_t;

  logic [31:0]       mem_r [0:MEM_DEPTH-1];
  state_t            state_r;
  logic [WAIT_W-1:0] wait_r;
  logic [BEAT_W-1:0] beat_r;
  logic [21:0]       addr_r;
  logic              is_write_r;
  logic [REF_W-1:0]  ref_cnt_r;
  logic              pending_r;
  logic [31:0]       rd_data_r;
  logic              rd_valid_r;
  logic              wr_done_r;
  logic              ref_expire_s;

  // Addresses above the RAM depth alias onto low RAM.
  function automatic logic [MEM_ADDR_W-1:0] ram_index(input logic [21:0] addr);
    return addr[MEM_ADDR_W-1:0];
  endfunction

  assign ref_expire_s = (ref_cnt_r == REF_LAST);

  // Free-running refresh interval counter.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ref_cnt_r <= {REF_W{1'b0}};
    end else if (ref_expire_s) begin
      ref_cnt_r <= {REF_W{1'b0}};
    end else begin
      ref_cnt_r <= ref_cnt_r + REF_W'(1);
    end
  end

  // RAM write port; addr_r holds the current beat address during a write burst.
  always_ff @(posedge i_Clk) begin
    if (wr_done_r) begin
      mem_r[ram_index(addr_r)] <= bus.i_Data_Write;
    end
  end

  // Command sequencer, refresh arbitration and registered strobes.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r    <= ST_IDLE;
      wait_r     <= WAIT_ZERO;
      beat_r     <= {BEAT_W{1'b0}};
      addr_r     <= 22'd0;
      is_write_r <= 1'b0;
      pending_r  <= 1'b0;
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
      wr_done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pending_r && bus.i_SDRAM_Yield) begin
            pending_r <= 1'b0;
            wait_r    <= REF_LOAD;
            state_r   <= ST_REFRESH;
          end else if (bus.i_Command == CMD_READ || bus.i_Command == CMD_WRITE) begin
            addr_r     <= bus.i_Data_Address;
            is_write_r <= (bus.i_Command == CMD_WRITE);
            wait_r     <= ACT_LOAD;
            state_r    <= ST_ACTIVATE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACTIVATE: begin
          if (wait_r != WAIT_ZERO) begin
            wait_r <= wait_r - WAIT_W'(1);
          end else if (is_write_r) begin
            beat_r    <= {BEAT_W{1'b0}};
            wr_done_r <= 1'b1;
            state_r   <= ST_WRITE_BURST;
          end else if (READ_LATENCY == 0) begin
            rd_data_r  <= mem_r[ram_index(addr_r)];
            rd_valid_r <= 1'b1;
            addr_r     <= addr_r + 22'd1;
            beat_r     <= {BEAT_W{1'b0}};
            state_r    <= ST_READ_BURST;
          end else begin
            wait_r  <= RL_LOAD;
            state_r <= ST_READ_WAIT;
          end
        end
        ST_READ_WAIT: begin
          if (wait_r != WAIT_ZERO) begin
            wait_r <= wait_r - WAIT_W'(1);
          end else begin
            rd_data_r  <= mem_r[ram_index(addr_r)];
            rd_valid_r <= 1'b1;
            addr_r     <= addr_r + 22'd1;
            beat_r     <= {BEAT_W{1'b0}};
            state_r    <= ST_READ_BURST;
          end
        end
        ST_READ_BURST: begin
          // Each edge loads the next beat so the burst streams without bubbles.
          if (beat_r == LAST_BEAT) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= 32'd0;
            state_r    <= ST_GAP;
          end else begin
            rd_data_r <= mem_r[ram_index(addr_r)];
            addr_r    <= addr_r + 22'd1;
            beat_r    <= beat_r + BEAT_W'(1);
          end
        end
        ST_WRITE_BURST: begin
          addr_r <= addr_r + 22'd1;
          if (beat_r == LAST_BEAT) begin
            wr_done_r <= 1'b0;
            state_r   <= ST_GAP;
          end else begin
            beat_r <= beat_r + BEAT_W'(1);
          end
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
        end
        ST_REFRESH: begin
          if (wait_r != WAIT_ZERO) begin
            wait_r <= wait_r - WAIT_W'(1);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          rd_valid_r <= 1'b0;
          wr_done_r  <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
      // A fresh expiry wins over the clear on refresh entry; repeats do not queue.
      if (ref_expire_s) begin
        pending_r <= 1'b1;
      end
    end
  end

  assign bus.o_Data_Read       = rd_data_r;
  assign bus.o_Data_Read_Valid = rd_valid_r;
  assign bus.o_Data_Write_Done = wr_done_r;
  assign bus.o_SDRAM_Requested = pending_r;

endmodule

// File: doc/sdram_port_model.md
Name: sdram_port_model

Overview:
- Memory-side responder for the SDRAM client command interface (IDLE/READ/WRITE command, 22-bit word address, 32-bit data, read-valid/write-done strobes, request/yield refresh handshake).
- Backed by on-chip RAM, with burst sequencing, activation and CAS-style latency, and periodic refresh arbitration.
- Stands in for the SDRAM controller so that compute clients (pixel/data FIFO processors) can be exercised on-chip and in simulation against the exact port timing.

Parameters:
- BURST_LEN, 8: words per burst; equals READ_BURST_LENGTH.
- ACT_CYCLES, 2: activation delay after command accept (≥1).
- READ_LATENCY, 2: extra delay before the first read beat (≥0).
- MEM_ADDR_W, 12: RAM depth is 2^MEM_ADDR_W words; the address low bits index the RAM.
- REFRESH_INTERVAL, 780: cycles between refresh requests.
- REFRESH_CYCLES, 8: duration of the refresh busy period.

Ports:
- i_Clk  in  1  clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Command  in  2  0=CMD_IDLE, 1=CMD_READ, 2=CMD_WRITE; 3 is treated as IDLE
- i_Data_Address  in  22  word address; sampled at burst start only
- i_Data_Write  in  32  write data for the current beat
- o_Data_Read  out  32  read data, valid with o_Data_Read_Valid
- o_Data_Read_Valid  out  1  one read beat per high cycle
- o_Data_Write_Done  out  1  i_Data_Write is consumed in this cycle
- o_SDRAM_Requested  out  1  refresh pending; client should yield
- i_SDRAM_Yield  in  1  client is idle and grants refresh

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0; state IDLE.
  - Refresh counter and pending flag cleared.
  - RAM contents are not cleared.
  - Reset mid-burst aborts the burst immediately; no further strobes are emitted.
- States: IDLE, ACTIVATE, READ_WAIT, READ_BURST, WRITE_BURST, GAP, REFRESH.
- IDLE priority, evaluated every cycle:
  - (1) pending && i_SDRAM_Yield → REFRESH.
  - (2) i_Command==READ/WRITE → latch base=i_Data_Address and the direction; go to ACTIVATE.
  - (3) otherwise stay in IDLE.
  - A pending refresh without yield never blocks a client command. Refresh is deferred until the client yields.
- ACTIVATE: lasts ACT_CYCLES cycles.
  - Read → READ_WAIT, or READ_BURST directly if READ_LATENCY=0.
  - Write → WRITE_BURST.
- READ_WAIT: lasts READ_LATENCY cycles, then → READ_BURST.
- READ_BURST: BURST_LEN consecutive cycles. In beat k (k=0..BURST_LEN-1): o_Data_Read_Valid=1 and o_Data_Read=RAM[(base+k) mod 2^22, low MEM_ADDR_W bits].
  - Registered RAM read is pipelined so that beats are back-to-back with no bubbles.
- WRITE_BURST: BURST_LEN consecutive cycles. In beat k: o_Data_Write_Done=1 and RAM[base+k] ← i_Data_Write sampled in that same cycle.
- Latency, with E0 = the edge at which IDLE accepts the command:
  - First read beat is high in the cycle after edge E0+ACT_CYCLES+READ_LATENCY (defaults: cycles 5..12 after E0).
  - First write beat is high in the cycle after E0+ACT_CYCLES.
- Command changes during ACTIVATE, READ_WAIT or bursts are ignored; an accepted burst always completes in full.
- GAP: exactly 1 cycle after every burst, strobes low, command ignored, then → IDLE.
  - The client returns to IDLE one cycle after its last strobe, so it never sees an extra beat.
  - Multi-burst transfers re-issue through IDLE with a freshly sampled address.
- Refresh:
  - The counter counts every cycle, including during REFRESH. On reaching REFRESH_INTERVAL-1 it sets pending and restarts from 0.
  - A second expiry while already pending does not queue another refresh.
  - o_SDRAM_Requested = pending, registered.
  - On entering REFRESH, pending clears; REFRESH lasts REFRESH_CYCLES cycles with all strobes low and commands ignored, then → IDLE.
- Address wrap: base+k wraps modulo 2^22; addresses ≥ 2^MEM_ADDR_W alias onto low RAM.
- At most one of o_Data_Read_Valid and o_Data_Write_Done is high in any cycle.

Test Plan:
- Write burst: WRITE at 0x000010 with data 0xA0..0xA7 presented per Write_Done → Done high exactly 8 cycles, first in the cycle after E0+2; then READ at 0x000010 → Valid 8 cycles from the cycle after E0+4, data 0xA0..0xA7, then a 1-cycle GAP.
- Multi-burst read, client holding READ with address advancing per beat (0x20000 range, 64 words) → 8 bursts, each separated by GAP+ACTIVATE+READ_WAIT, beat addresses contiguous; no beat emitted after the client drops to IDLE.
- Refresh without a command: after 780 cycles Requested=1; Yield asserted 3 cycles later → Requested drops next edge, 8-cycle REFRESH, then IDLE accepts a READ.
- Refresh during a transfer: pending rises mid-burst and the client issues the next burst without yielding → burst served; refresh starts only once Yield=1 in IDLE; Requested stays 1 meanwhile.
- Wrap and alias: WRITE at 0x3FFFFC with 8 words → words land at RAM indices 0xFFC..0xFFF then 0x000..0x003; read back matches.
- Reset mid-burst: i_Rst_n low at read beat 3 → all outputs 0 asynchronously; after release, IDLE with Requested=0; earlier RAM contents are intact on read-back.
